control_carro: RTL and testbench

CONTROL_CARRO -- requirements
Module: control_carro

---
 rtl/carro_pkg.sv | 32 +++
 rtl/control_carro_divisor_pasos.sv | 51 +++++
 rtl/control_carro.sv | 138 +++++++++++++
 tb/tb_control_carro.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/carro_pkg.sv
// carro_pkg -- shared definitions for the car controller.
//   * estado_t       : FSM state encoding
//   * *_DEF          : default values for the control_carro parameters
//   * NIVEL_MAX      : highest difficulty level (oNivel saturates here)
//   * calcDivisor()  : frame ticks per pixel step for a given level
package carro_pkg;

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        CARGA  = 3'd1,
        CORRE  = 3'd2,
        PAUSA  = 3'd3,
        SALTO  = 3'd4,
        FIN    = 3'd5
    } estado_t;

    localparam logic [9:0] LIMITE_X_DEF      = 10'd479;
    localparam logic [3:0] PASOS_INICIAL_DEF = 4'd4;
    localparam logic [3:0] VUELTAS_NIVEL_DEF = 4'd8;
    localparam logic [2:0] NIVEL_MAX         = 3'd7;

    // max(pasos - nivel, 1) evaluated at 4 bits; the compare comes first so
    // the subtraction can never wrap.
    function automatic logic [3:0] calcDivisor(input logic [3:0] pasos,
                                               input logic [2:0] nivel);
        if ({1'b0, nivel} >= pasos)
            return 4'd1;
        else
            return pasos - {1'b0, nivel};
    endfunction

endpackage

// File: rtl/control_carro_divisor_pasos.sv
// divisor_pasos -- frame-tick divider that paces the car's pixel steps.
// Ports:
//   iClk    system clock
//   iReset  asynchronous active-high reset
//   iTick   one-cycle pulse per video frame
//   iNivel  current difficulty level (sets the divisor)
//   iClear  synchronous counter clear (wins over everything else)
//   iHold   freezes the counter and ignores iTick
//   oPaso   registered one-cycle step pulse, one cycle after the
//           iTick that completes a divisor period
module divisor_pasos
    import carro_pkg::*;
#(
    parameter logic [3:0] PASOS_INICIAL = PASOS_INICIAL_DEF
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iTick,
    input  logic [2:0] iNivel,
    input  logic       iClear,
    input  logic       iHold,
    output logic       oPaso
);

    logic [3:0] cuenta;
    logic [3:0] divisor;

    assign divisor = calcDivisor(PASOS_INICIAL, iNivel);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            cuenta <= 4'd0;
            oPaso  <= 1'b0;
        end else begin
            oPaso <= 1'b0;
            if (iClear) begin
                cuenta <= 4'd0;
            end else if (!iHold && iTick) begin
                // '>=' rather than '==' so a count left above a shrunken
                // divisor can never run away for 16 ticks.
                if (cuenta >= divisor - 4'd1) begin
                    cuenta <= 4'd0;
                    oPaso  <= 1'b1;
                end else begin
                    cuenta <= cuenta + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/control_carro.sv
// control_carro -- game-flow FSM for the car: start, run, pause, respawn at
// the road edge, level progression and game over.
// Ports:
//   iClk, iReset              clock and asynchronous active-high reset
//   iTick                     one-cycle pulse per video frame
//   iStart, iPausa, iColision level-sensitive player/game requests
//   iPosicionX                current car X position
//   oEnable / oSuma / oSalto  mutually exclusive registered one-cycle pulses
//                             (load, advance, respawn) to the position register
//   oNivel                    current difficulty level (0..7)
//   oActivo                   high in CORRE or PAUSA
//   oFin                      high in FIN
module control_carro
    import carro_pkg::*;
#(
    parameter logic [9:0] LIMITE_X      = LIMITE_X_DEF,
    parameter logic [3:0] PASOS_INICIAL = PASOS_INICIAL_DEF,
    parameter logic [3:0] VUELTAS_NIVEL = VUELTAS_NIVEL_DEF
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iTick,
    input  logic       iStart,
    input  logic       iPausa,
    input  logic       iColision,
    input  logic [9:0] iPosicionX,
    output logic       oEnable,
    output logic       oSuma,
    output logic       oSalto,
    output logic [2:0] oNivel,
    output logic       oActivo,
    output logic       oFin
);

    estado_t    estado;
    logic [2:0] nivel;
    logic [3:0] vueltas;
    logic       enableReg;
    logic       saltoReg;
    logic       activoReg;
    logic       finReg;

    logic enCorre;
    logic fueraPista;
    logic limpiarCuenta;
    logic congelarCuenta;

    assign enCorre    = (estado == CORRE);
    assign fueraPista = (iPosicionX >= LIMITE_X);

    // The counter clears on a (re)start and when the car leaves the road; it
    // only advances in CORRE when no higher-priority event owns the cycle.
    assign limpiarCuenta  = (((estado == REPOSO) || (estado == FIN)) && iStart)
                          || (enCorre && !iColision && fueraPista);
    assign congelarCuenta = !(enCorre && !iColision && !fueraPista && !iPausa);

    divisor_pasos #(
        .PASOS_INICIAL(PASOS_INICIAL)
    ) uDivisor (
        .iClk   (iClk),
        .iReset (iReset),
        .iTick  (iTick),
        .iNivel (nivel),
        .iClear (limpiarCuenta),
        .iHold  (congelarCuenta),
        .oPaso  (oSuma)
    );

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            estado    <= REPOSO;
            nivel     <= 3'd0;
            vueltas   <= 4'd0;
            enableReg <= 1'b0;
            saltoReg  <= 1'b0;
            activoReg <= 1'b0;
            finReg    <= 1'b0;
        end else begin
            enableReg <= 1'b0;
            saltoReg  <= 1'b0;
            case (estado)
                REPOSO, FIN: begin
                    if (iStart) begin
                        estado    <= CARGA;
                        nivel     <= 3'd0;
                        vueltas   <= 4'd0;
                        enableReg <= 1'b1;
                        finReg    <= 1'b0;
                    end
                end
                CARGA: begin
                    estado    <= CORRE;
                    activoReg <= 1'b1;
                end
                CORRE: begin
                    if (iColision) begin
                        estado    <= FIN;
                        activoReg <= 1'b0;
                        finReg    <= 1'b1;
                    end else if (fueraPista) begin
                        estado    <= SALTO;
                        activoReg <= 1'b0;
                        saltoReg  <= 1'b1;
                    end else if (iPausa) begin
                        estado <= PAUSA;
                    end
                end
                SALTO: begin
                    estado    <= CORRE;
                    activoReg <= 1'b1;
                    if (vueltas + 4'd1 >= VUELTAS_NIVEL) begin
                        vueltas <= 4'd0;
                        if (nivel != NIVEL_MAX)
                            nivel <= nivel + 3'd1;
                    end else begin
                        vueltas <= vueltas + 4'd1;
                    end
                end
                PAUSA: begin
                    if (!iPausa)
                        estado <= CORRE;
                end
                default: begin
                    estado    <= REPOSO;
                    activoReg <= 1'b0;
                    finReg    <= 1'b0;
                end
            endcase
        end
    end

    assign oEnable = enableReg;
    assign oSalto  = saltoReg;
    assign oNivel  = nivel;
    assign oActivo = activoReg;
    assign oFin    = finReg;

endmodule

// File: tb/tb_control_carro.sv
module tb_control_carro;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iTick;
    logic       iStart;
    logic       iPausa;
    logic       iColision;
    logic [9:0] iPosicionX;
    logic       oEnable;
    logic       oSuma;
    logic       oSalto;
    logic [2:0] oNivel;
    logic       oActivo;
    logic       oFin;

    int nAserciones = 0;
    int nFallas     = 0;

    always #5 iClk = ~iClk;

    control_carro dut (
        .iClk       (iClk),
        .iReset     (iReset),
        .iTick      (iTick),
        .iStart     (iStart),
        .iPausa     (iPausa),
        .iColision  (iColision),
        .iPosicionX (iPosicionX),
        .oEnable    (oEnable),
        .oSuma      (oSuma),
        .oSalto     (oSalto),
        .oNivel     (oNivel),
        .oActivo    (oActivo),
        .oFin       (oFin)
    );

    task automatic chequear(input string tag, input int obs, input int esp);
        nAserciones++;
        if (obs !== esp) begin
            nFallas++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, esp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
        end
    endtask

    // One frame tick: oSuma is checked on the cycle right after the tick
    // edge, and again one cycle later where it must already be low.
    task automatic tick(input string tag, input int sumaEsp);
        iTick = 1'b1;
        @(negedge iClk);
        iTick = 1'b0;
        chequear({tag, "_suma"}, int'(oSuma), sumaEsp);
        @(negedge iClk);
        chequear({tag, "_suma_baja"}, int'(oSuma), 0);
    endtask

    // One lap: car reaches the road edge together with a frame tick; the
    // edge must win, giving a single oSalto and no oSuma.
    task automatic vuelta(input string tag);
        iPosicionX = 10'd479;
        iTick      = 1'b1;
        @(negedge iClk);
        iPosicionX = 10'd0;
        iTick      = 1'b0;
        chequear({tag, "_salto"}, int'(oSalto), 1);
        chequear({tag, "_suma"}, int'(oSuma), 0);
        @(negedge iClk);
        chequear({tag, "_salto_baja"}, int'(oSalto), 0);
    endtask

    task automatic vueltas(input string tag, input int n);
        for (int i = 0; i < n; i++) vuelta(tag);
    endtask

    task automatic arrancar(input string tag);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chequear({tag, "_enable"}, int'(oEnable), 1);
        chequear({tag, "_nivel"}, int'(oNivel), 0);
        @(negedge iClk);
        chequear({tag, "_enable_baja"}, int'(oEnable), 0);
        chequear({tag, "_activo"}, int'(oActivo), 1);
    endtask

    initial begin
        iReset     = 1'b1;
        iTick      = 1'b0;
        iStart     = 1'b0;
        iPausa     = 1'b0;
        iColision  = 1'b0;
        iPosicionX = 10'd0;
        repeat (2) @(negedge iClk);
        chequear("rst_enable", int'(oEnable), 0);
        chequear("rst_suma", int'(oSuma), 0);
        chequear("rst_salto", int'(oSalto), 0);
        chequear("rst_nivel", int'(oNivel), 0);
        chequear("rst_activo", int'(oActivo), 0);
        chequear("rst_fin", int'(oFin), 0);
        iReset = 1'b0;
        @(negedge iClk);
        chequear("reposo_activo", int'(oActivo), 0);

        // Start and level-0 pacing: divisor 4
        arrancar("inicio");
        for (int i = 0; i < 8; i++)
            tick($sformatf("n0_tick%0d", i + 1), (i % 4 == 3) ? 1 : 0);

        // 8 laps -> level 1, divisor 3
        vueltas("v_n1", 8);
        chequear("nivel_1", int'(oNivel), 1);
        for (int i = 0; i < 6; i++)
            tick($sformatf("n1_tick%0d", i + 1), (i % 3 == 2) ? 1 : 0);

        // 32 more laps -> level 5, divisor 1
        vueltas("v_n5", 32);
        chequear("nivel_5", int'(oNivel), 5);
        tick("n5_tick1", 1);
        tick("n5_tick2", 1);

        // Up to 7, then saturate
        vueltas("v_n7", 16);
        chequear("nivel_7", int'(oNivel), 7);
        vueltas("v_sat", 8);
        chequear("nivel_sat", int'(oNivel), 7);

        // Collision beats edge and tick
        iColision  = 1'b1;
        iPosicionX = 10'd480;
        iTick      = 1'b1;
        @(negedge iClk);
        iColision  = 1'b0;
        iPosicionX = 10'd0;
        iTick      = 1'b0;
        chequear("col_fin", int'(oFin), 1);
        chequear("col_salto", int'(oSalto), 0);
        chequear("col_suma", int'(oSuma), 0);
        chequear("col_activo", int'(oActivo), 0);
        @(negedge iClk);
        chequear("fin_espera", int'(oFin), 1);
        arrancar("reinicio");
        chequear("reinicio_fin", int'(oFin), 0);

        // Pause mid-count (counter = 2)
        tick("p_tick1", 0);
        tick("p_tick2", 0);
        iPausa = 1'b1;
        @(negedge iClk);
        chequear("pausa_activo", int'(oActivo), 1);
        for (int i = 0; i < 10; i++) tick($sformatf("pausa_tick%0d", i + 1), 0);
        iColision = 1'b1;
        @(negedge iClk);
        iColision = 1'b0;
        @(negedge iClk);
        chequear("pausa_sin_fin", int'(oFin), 0);
        iPausa = 1'b0;
        @(negedge iClk);
        tick("post_pausa1", 0);
        tick("post_pausa2", 1);

        // Level 3 then asynchronous reset during pause
        vueltas("v_n3", 24);
        chequear("nivel_3", int'(oNivel), 3);
        iPausa = 1'b1;
        @(negedge iClk);
        #2;
        iReset = 1'b1;
        #1;
        chequear("arst_nivel", int'(oNivel), 0);
        chequear("arst_activo", int'(oActivo), 0);
        chequear("arst_enable", int'(oEnable), 0);
        chequear("arst_suma", int'(oSuma), 0);
        chequear("arst_salto", int'(oSalto), 0);
        chequear("arst_fin", int'(oFin), 0);
        @(negedge iClk);
        iPausa = 1'b0;
        iReset = 1'b0;
        repeat (3) @(negedge iClk);
        chequear("post_rst_reposo", int'(oActivo), 0);
        chequear("post_rst_enable", int'(oEnable), 0);
        arrancar("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAserciones, nFallas);
        $finish;
    end

endmodule
